ibex_data_bus_arbiter: RTL
==========================

IBEX_DATA_BUS_ARBITER -- requirements
Module: ibex_data_bus_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, max accepted-but-unanswered transactions (legal 1..4).
REQ-002 SHALL have ports clk_i input 1 clock; rst_i input 1 reset; one clock, reset asynchronous active-high.
REQ-003 SHALL have, per host n in {0,1}: hn_req_i input 1 request; hn_lock_i input 1 hold ownership after this grant; hn_we_i input 1; hn_be_i input 4; hn_addr_i input 32; hn_wdata_i input 32.
REQ-004 SHALL have, per host n: hn_gnt_o output 1; hn_rvalid_o output 1; hn_err_o output 1; hn_rdata_o output 32.
REQ-005 SHALL have device ports data_req_o output 1; data_gnt_i input 1; data_rvalid_i input 1; data_err_i input 1; data_addr_o output 32; data_we_o output 1; data_be_o output 4; data_wdata_o output 32; data_rdata_i input 32.
REQ-006 SHALL have busy_o output 1 (outstanding count nonzero) and spurious_rvalid_o output 1 (pulse).

Function
REQ-007 SHALL use the req/gnt/rvalid protocol: host holds req and fields stable until gnt; responses return in order, one per accepted request.
REQ-008 SHALL keep state ARB, LOCK0, LOCK1; ARB selects per cycle, LOCKn forces selection of host n.
REQ-009 In ARB, SHALL select the sole requester; if both request, select host != last_q (round-robin); if none, select host 0.
REQ-010 SHALL drive data_req_o = selected host req AND NOT full; addr/we/be/wdata muxed from selected host combinationally (zero added latency).
REQ-011 SHALL assert hn_gnt_o = data_gnt_i AND data_req_o AND selected==n; never to the unselected host.
REQ-012 On handshake SHALL push owner ID into ordering FIFO, set last_q to owner, go to LOCKn if hn_lock_i=1, else ARB.
REQ-013 In LOCKn SHALL return to ARB on handshake with hn_lock_i=0, or when hn_req_i=0 and hn_lock_i=0 together.
REQ-014 full = count==MaxOutstanding; push SHALL be blocked when full even if a pop occurs in the same cycle.
REQ-015 On data_rvalid_i with count>0 SHALL pop FIFO head and pulse hn_rvalid_o, hn_err_o=data_err_i for head owner only, same cycle.
REQ-016 hn_rdata_o SHALL equal data_rdata_i for both hosts unconditionally.
REQ-017 On data_rvalid_i with count==0 SHALL pulse spurious_rvalid_o one cycle, route nothing, leave count at 0.
REQ-018 Simultaneous push and pop SHALL leave count unchanged with FIFO order preserved.
REQ-019 Pointers SHALL wrap modulo MaxOutstanding; count width clog2(MaxOutstanding+1).

Reset
REQ-020 On rst_i SHALL asynchronously set state=ARB, last_q=1 (host 0 wins first tie), FIFO pointers and count=0.
REQ-021 During reset SHALL drive data_req_o, all gnt/rvalid/err, busy_o, spurious_rvalid_o to 0; responses to pre-reset requests are dropped.
REQ-022 Reset asserted mid-transaction SHALL discard all outstanding IDs; a following rvalid counts as spurious.

Structure
REQ-023 Host ID type, state enum (ARB/LOCK0/LOCK1) and MaxOutstanding default SHALL live in ibex_pkg.
REQ-024 Ordering FIFO SHALL be sub-module ibex_bus_id_fifo (1-bit ID, depth MaxOutstanding, push/pop/full/empty/head).
REQ-025 Implementation SHALL be 120-400 lines RTL, no latches, no combinational path gnt->req.

Verification
REQ-026 Both hosts request, data_gnt_i=1 every cycle, rvalid 1 cycle later -> grants alternate 0,1,0,1; each rvalid to the granted host in order.
REQ-027 h0 req lock=1 addr 0x1001, then lock=0 addr 0x1004, h1 requesting throughout -> h0 gets both grants back-to-back, h1 granted third.
REQ-028 MaxOutstanding=2, three h1 requests, no rvalid -> third not forwarded (data_req_o=0) until first rvalid; then forwarded next cycle.
REQ-029 rvalid with data_err_i=1 while head owner=1 -> h1_rvalid_o=h1_err_o=1, h0_rvalid_o=0, count decrements.
REQ-030 rvalid with count=0 -> spurious_rvalid_o=1 one cycle, no host rvalid; rst_i pulsed with count=2 -> busy_o=0 immediately, state ARB.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types for the Ibex data-bus arbiter: host IDs, arbitration states and
// the per-host request bundle used to mux the winning host onto the device port.
package ibex_pkg;

   localparam int unsigned MaxOutstandingDefault = 2;

   typedef logic host_id_t;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic        req;
      logic        lock;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } host_req_t;

   function automatic arb_state_e lock_state(input host_id_t id);
      return id ? LOCK1 : LOCK0;
   endfunction

endpackage

// File: rtl/ibex_bus_id_fifo.sv
// Ordering FIFO of host IDs for accepted-but-unanswered transactions, so each
// response is routed back to the host that issued the matching request.
module ibex_bus_id_fifo
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = MaxOutstandingDefault
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  host_id_t id_i,
   input  logic     pop_i,
   output logic     full_o,
   output logic     empty_o,
   output host_id_t head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

   host_id_t        mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            push_ok, pop_ok;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
      return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
   endfunction

   assign full_o  = (count_q == FullCnt);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // NOTE: storage is deliberately not reset; count_q alone defines which
   // entries are valid, so stale IDs after reset are never read.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= id_i;
   end

   // NOTE: every register is updated with <= so all reads in this block see
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ibex_data_bus_arbiter.sv
// Two-host arbiter onto one req/gnt/rvalid data bus: round-robin with optional
// lock, bounded outstanding transactions, in-order response routing.
module ibex_data_bus_arbiter
   import ibex_pkg::*;
#(
   parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        h0_req_i,
   input  logic        h0_lock_i,
   input  logic        h0_we_i,
   input  logic [3:0]  h0_be_i,
   input  logic [31:0] h0_addr_i,
   input  logic [31:0] h0_wdata_i,
   output logic        h0_gnt_o,
   output logic        h0_rvalid_o,
   output logic        h0_err_o,
   output logic [31:0] h0_rdata_o,
   input  logic        h1_req_i,
   input  logic        h1_lock_i,
   input  logic        h1_we_i,
   input  logic [3:0]  h1_be_i,
   input  logic [31:0] h1_addr_i,
   input  logic [31:0] h1_wdata_i,
   output logic        h1_gnt_o,
   output logic        h1_rvalid_o,
   output logic        h1_err_o,
   output logic [31:0] h1_rdata_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i,
   output logic        busy_o,
   output logic        spurious_rvalid_o
);

   host_req_t  host [2];
   host_req_t  sel_host;
   arb_state_e state_q;
   host_id_t   last_q, sel, head;
   logic       full, empty, handshake, pop;

   assign host[0] = '{req: h0_req_i, lock: h0_lock_i, we: h0_we_i, be: h0_be_i,
                      addr: h0_addr_i, wdata: h0_wdata_i};
   assign host[1] = '{req: h1_req_i, lock: h1_lock_i, we: h1_we_i, be: h1_be_i,
                      addr: h1_addr_i, wdata: h1_wdata_i};

   // NOTE: sel gets a default before the case so every path assigns it and
   // no latch is inferred.
   always_comb begin
      sel = 1'b0;
      case (state_q)
         LOCK0:   sel = 1'b0;
         LOCK1:   sel = 1'b1;
         default: begin
            if (host[0].req && host[1].req) sel = ~last_q;
            else if (host[1].req)           sel = 1'b1;
         end
      endcase
   end

   assign sel_host = host[sel];

   // Request depends only on host inputs and local state, never on data_gnt_i.
   assign data_req_o   = sel_host.req & ~full & ~rst_i;
   assign data_addr_o  = sel_host.addr;
   assign data_we_o    = sel_host.we;
   assign data_be_o    = sel_host.be;
   assign data_wdata_o = sel_host.wdata;

   assign handshake = data_req_o & data_gnt_i;
   assign h0_gnt_o  = handshake & (sel == 1'b0);
   assign h1_gnt_o  = handshake & (sel == 1'b1);

   assign pop               = data_rvalid_i & ~empty & ~rst_i;
   assign spurious_rvalid_o = data_rvalid_i & empty & ~rst_i;
   assign h0_rvalid_o       = pop & (head == 1'b0);
   assign h1_rvalid_o       = pop & (head == 1'b1);
   assign h0_err_o          = h0_rvalid_o & data_err_i;
   assign h1_err_o          = h1_rvalid_o & data_err_i;
   assign h0_rdata_o        = data_rdata_i;
   assign h1_rdata_o        = data_rdata_i;
   assign busy_o            = ~empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ARB;
         last_q  <= 1'b1;
      end else if (handshake) begin
         last_q  <= sel;
         state_q <= sel_host.lock ? lock_state(sel) : ARB;
      end else if (state_q != ARB && !sel_host.req && !sel_host.lock) begin
         state_q <= ARB;
      end
   end

   ibex_bus_id_fifo #(
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (handshake),
      .id_i    (sel),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head)
   );

endmodule
